// File: rtl/arb_pkg.sv
// arb_pkg: state encoding, client indices and pointer reset helper shared by mem_arbiter.
package arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;
  localparam int CLIENT_VGA = 0;
  localparam int CLIENT_CPU = 1;
  localparam int CLIENT_UART = 2;
  // Last non-priority index, so the first search lands on the lowest non-priority client.
  function automatic int rr_init(input int n, input int prio);
    return (prio == n - 1) ? n - 2 : n - 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first requesting index after ptr_i (circular), never returning excl_i.
module rr_pick #(
  parameter int N = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic [IDX_W-1:0] excl_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);
  logic [IDX_W-1:0] c;
  // Scan farthest-first so the nearest hit after the pointer is the one that sticks.
  always_comb begin
    found_o = 1'b0;
    idx_o = '0;
    c = '0;
    for (int k = N; k >= 1; k--) begin
      c = IDX_W'((int'(ptr_i) + k) % N);
      if (req_i[c] && c != excl_i) begin
        found_o = 1'b1;
        idx_o = c;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-client memory arbiter with one absolute-priority client and round robin for the rest.
// Define ARB_TIMEOUT_EN to add the mem_busy watchdog and the err output.
module mem_arbiter import arb_pkg::*; #(
  parameter int NUM_CLIENTS = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int PRIO_CLIENT = CLIENT_VGA,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int SEL_W = DATA_W / 8,
  localparam int IDX_W = $clog2(NUM_CLIENTS)
) (
  input  logic                          clk,
  input  logic                          nRst,
  input  logic [NUM_CLIENTS-1:0]        req,
  input  logic [NUM_CLIENTS-1:0]        we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] adr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] wdata,
  input  logic [NUM_CLIENTS*SEL_W-1:0]  sel,
  input  logic                          prio_hold,
  output logic [NUM_CLIENTS-1:0]        gnt,
  output logic [NUM_CLIENTS-1:0]        ack,
  output logic [DATA_W-1:0]             rdata,
`ifdef ARB_TIMEOUT_EN
  output logic                          err,
`endif
  output logic                          mem_we,
  output logic                          mem_re,
  output logic [ADDR_W-1:0]             mem_adr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [SEL_W-1:0]              mem_sel,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_busy
);
  localparam logic [IDX_W-1:0] PRIO_IDX = IDX_W'(PRIO_CLIENT);
  localparam logic [IDX_W-1:0] RR_INIT = IDX_W'(rr_init(NUM_CLIENTS, PRIO_CLIENT));

  if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8 || PRIO_CLIENT >= NUM_CLIENTS || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("mem_arbiter: illegal parameter combination");
  end

  arb_state_t state_q, state_d;
  logic [NUM_CLIENTS-1:0] gnt_q, ack_q;
  logic [DATA_W-1:0] rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0] mem_adr_q;
  logic [SEL_W-1:0] mem_sel_q;
  logic mem_we_q, mem_re_q, wr_q;
  logic [IDX_W-1:0] rr_q, win_q, pick_idx, win_idx;
  logic pick_found, win_found, tmo, done;

  rr_pick #(.N(NUM_CLIENTS), .IDX_W(IDX_W)) u_pick (
    .req_i(req),
    .ptr_i(rr_q),
    .excl_i(PRIO_IDX),
    .found_o(pick_found),
    .idx_o(pick_idx)
  );

  // prio_hold only blocks the round-robin clients; the priority client itself still wins.
  assign win_found = req[PRIO_CLIENT] || (!prio_hold && pick_found);
  assign win_idx = req[PRIO_CLIENT] ? PRIO_IDX : pick_idx;
  assign done = state_q == ARB_WAIT && (!mem_busy || tmo);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q;
  logic err_q;
  assign tmo = mem_busy && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  assign err = err_q;
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= state_q == ARB_ISSUE ? '0 : (state_q == ARB_WAIT && mem_busy) ? cnt_q + 1'b1 : cnt_q;
      err_q <= state_q == ARB_WAIT && tmo;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  state_d = win_found ? ARB_ISSUE : ARB_IDLE;
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT:  state_d = done ? ARB_RESP : ARB_WAIT;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= ARB_IDLE;
      gnt_q <= '0;
      ack_q <= '0;
      rdata_q <= '0;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      mem_adr_q <= '0;
      mem_wdata_q <= '0;
      mem_sel_q <= '0;
      wr_q <= 1'b0;
      win_q <= '0;
      rr_q <= RR_INIT;
    end else begin
      state_q <= state_d;
      case (state_q)
        ARB_IDLE: if (win_found) begin
          gnt_q <= NUM_CLIENTS'(1) << win_idx;
          win_q <= win_idx;
          wr_q <= we[win_idx];
          mem_we_q <= we[win_idx];
          mem_re_q <= !we[win_idx];
          mem_adr_q <= adr[int'(win_idx)*ADDR_W +: ADDR_W];
          mem_wdata_q <= wdata[int'(win_idx)*DATA_W +: DATA_W];
          mem_sel_q <= sel[int'(win_idx)*SEL_W +: SEL_W];
        end
        ARB_ISSUE: begin
          mem_we_q <= 1'b0;
          mem_re_q <= 1'b0;
        end
        ARB_WAIT: if (done) begin
          ack_q <= gnt_q;
          if (!wr_q && !mem_busy) rdata_q <= mem_rdata;
        end
        default: begin
          ack_q <= '0;
          gnt_q <= '0;
          mem_adr_q <= '0;
          mem_wdata_q <= '0;
          mem_sel_q <= '0;
          if (win_q != PRIO_IDX) rr_q <= win_q;
        end
      endcase
    end
  end

  assign gnt = gnt_q;
  assign ack = ack_q;
  assign rdata = rdata_q;
  assign mem_we = mem_we_q;
  assign mem_re = mem_re_q;
  assign mem_adr = mem_adr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_sel = mem_sel_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transactions checked against a transaction-level model.
module tb_mem_arbiter;
  localparam int N = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int P = 0;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 8;
  logic err;
`endif
  logic clk = 1'b0;
  logic nRst, prio_hold, mem_we, mem_re, mem_busy;
  logic [N-1:0] req, we, gnt, ack;
  logic [N*AW-1:0] adr;
  logic [N*DW-1:0] wdata;
  logic [N*SW-1:0] sel;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_adr;
  logic [SW-1:0] mem_sel;
  int n_tests = 0;
  int n_fail = 0;
  int rr_m;
  logic [DW-1:0] rdata_m;

  always #5 clk = ~clk;

  mem_arbiter #(
    .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .PRIO_CLIENT(P)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk(clk), .nRst(nRst), .req(req), .we(we), .adr(adr), .wdata(wdata), .sel(sel),
    .prio_hold(prio_hold), .gnt(gnt), .ack(ack), .rdata(rdata),
`ifdef ARB_TIMEOUT_EN
    .err(err),
`endif
    .mem_we(mem_we), .mem_re(mem_re), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_busy(mem_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spec rule: priority client first, hold blocks the rest, else next requester after last served.
  function automatic int model_pick(input logic [N-1:0] r, input logic h);
    logic [N-1:0] m;
    if (r[P]) return P;
    if (h) return -1;
    for (int k = 1; k <= N; k++) begin
      m = r >> ((rr_m + k) % N);
      if ((rr_m + k) % N != P && m[0]) return (rr_m + k) % N;
    end
    return -1;
  endfunction

  task automatic rand_cmds();
    for (int i = 0; i < N; i++) begin
      adr[i*AW +: AW] = $urandom;
      wdata[i*DW +: DW] = $urandom;
      sel[i*SW +: SW] = SW'($urandom);
    end
    we = N'($urandom);
  endtask

  task automatic xact(input logic [N-1:0] r, input logic h, input int nbusy, input logic drop, input logic [DW-1:0] rd);
    int w = model_pick(r, h);
    logic [N-1:0] oh, t;
    logic [AW-1:0] a;
    logic wr;
    req = r;
    prio_hold = h;
    mem_busy = 1'b0;
    tick();
    if (w < 0) begin
      chk("no_winner_gnt", gnt, 0);
      req = '0;
      prio_hold = 1'b0;
      return;
    end
    oh = N'(1) << w;
    t = we >> w;
    wr = t[0];
    a = adr[w*AW +: AW];
    chk("issue_gnt", gnt, oh);
    chk("issue_strobe", {mem_we, mem_re}, {wr, !wr});
    chk("issue_adr", mem_adr, a);
    chk("issue_wdata", mem_wdata, wdata[w*DW +: DW]);
    chk("issue_sel", mem_sel, sel[w*SW +: SW]);
    if (drop) req = '0;
    prio_hold = 1'b0;
    tick();
    for (int j = 0; j <= nbusy; j++) begin
      mem_busy = j < nbusy;
      mem_rdata = (j == nbusy) ? rd : $urandom;
      chk("wait_ack", ack, 0);
      chk("wait_strobe", {mem_we, mem_re}, 0);
      chk("wait_adr", mem_adr, a);
      tick();
    end
    if (!wr) rdata_m = rd;
    chk("resp_ack", ack, oh);
    chk("resp_gnt", gnt, oh);
    chk("resp_rdata", rdata, rdata_m);
`ifdef ARB_TIMEOUT_EN
    chk("resp_err", err, 0);
`endif
    if (w != P) rr_m = w;
    req = '0;
    mem_busy = 1'b0;
    tick();
    chk("idle_ack", ack, 0);
    chk("idle_gnt", gnt, 0);
    chk("idle_mem", {mem_we, mem_re, mem_adr, mem_sel}, 0);
  endtask

  initial begin
    nRst = 1'b0;
    req = '0; we = '0; adr = '0; wdata = '0; sel = '0;
    prio_hold = 1'b0; mem_rdata = '0; mem_busy = 1'b0;
    rr_m = N - 1;
    rdata_m = '0;
    #1;
    chk("reset_gnt_ack", {gnt, ack}, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_mem", {mem_we, mem_re, mem_adr, mem_wdata, mem_sel}, 0);
    repeat (2) @(posedge clk);
    #1 nRst = 1'b1;
    tick();
    adr[1*AW +: AW] = 32'h100;
    we = '0;
    xact(3'b010, 1'b0, 0, 1'b0, 32'hDEADBEEF);
    chk("single_read_rdata", rdata, 32'hDEADBEEF);
    rand_cmds();
    xact(3'b111, 1'b0, 0, 1'b0, $urandom);
    for (int i = 0; i < 4; i++) xact(3'b110, 1'b0, 0, 1'b0, $urandom);
    rand_cmds();
    we = 3'b100;
    xact(3'b100, 1'b0, 5, 1'b0, $urandom);
    req = 3'b110;
    prio_hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_gnt", gnt, 0);
    end
    xact(3'b111, 1'b1, 0, 1'b0, $urandom);
    req = 3'b010;
    mem_busy = 1'b1;
    tick();
    tick();
    chk("rst_pre_gnt", gnt, 3'b010);
    #2 nRst = 1'b0;
    #1;
    chk("rst_gnt_ack", {gnt, ack}, 0);
    chk("rst_mem", {mem_we, mem_re, mem_adr, mem_wdata, mem_sel}, 0);
    chk("rst_rdata", rdata, 0);
    rr_m = N - 1;
    rdata_m = '0;
    req = '0;
    mem_busy = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
    tick();
    xact(3'b010, 1'b0, 0, 1'b0, $urandom);
    for (int i = 0; i < 200; i++) begin
      rand_cmds();
      xact(N'($urandom), ($urandom % 4) == 0, $urandom % 6, 1'($urandom), $urandom);
    end
`ifdef ARB_TIMEOUT_EN
    begin
      int cyc = 0;
      we = '0;
      req = 3'b010;
      mem_busy = 1'b1;
      tick();
      tick();
      while (ack == 0 && cyc < 100) begin
        tick();
        cyc++;
      end
      chk("tmo_cycles", cyc, TO);
      chk("tmo_ack", ack, 3'b010);
      chk("tmo_err", err, 1);
      chk("tmo_rdata", rdata, rdata_m);
      rr_m = 1;
      req = '0;
      mem_busy = 1'b0;
      tick();
      chk("tmo_err_clear", err, 0);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
